stream_denoise: RTL and testbench
=================================

// Module: stream_denoise
// PURPOSE
//  Streaming, pipelined successor to the combinational NxN neighbourhood denoiser.
//  Takes a raster-order stream of COLORS-bit one-hot/multi-hot colour-mask pixels and
//  builds the NxN window internally from N_SIZE-1 line buffers. Counts set bits per
//  colour and emits a denoised mask stream: one output beat per input beat.
//  Sits between the HSV colour classifier and the blob/centroid stage.
//  Adds a selectable fill mode and per-frame latched configuration.
// PARAMETERS
//  N_SIZE      5    window edge (odd, >=3); H = N_SIZE/2
//  COLORS      1    colour-mask channels, each processed independently
//  IMG_WIDTH   640  pixels per line
//  IMG_HEIGHT  480  lines per frame
//  DEF_THRESH  13   threshold loaded at reset
//  CW          $clog2(N_SIZE*N_SIZE+1)  count/threshold width (localparam)
// PORTS
//  clk            in   1       pixel clock
//  rst            in   1       synchronous, active-high reset
//  in_valid       in   1       input beat strobe; gaps allowed
//  in_sof         in   1       first pixel of frame; qualified by in_valid
//  in_pix         in   COLORS  colour mask of current pixel
//  cfg_threshold  in   CW      neighbourhood threshold, sampled at SOF beat
//  cfg_mode       in   1       0=clear (centre must be set), 1=fill; sampled at SOF beat
//  out_valid      out  1       output beat strobe
//  out_sof        out  1       in_sof delayed with its beat
//  out_border     out  1       window centre is within H of top/left/right image edge
//  out_pix        out  COLORS  denoised mask for window centre (x-H, y-H)
// BEHAVIOUR
//  - Reset: out_valid, out_sof, out_border, out_pix = 0; x = y = 0;
//    thr_q = DEF_THRESH; mode_q = 0. Line buffer and window contents are NOT cleared.
//  - Counters (advance only on in_valid):
//    - in_valid & in_sof: this beat uses x = y = 0.
//    - x wraps IMG_WIDTH-1 -> 0 and increments y.
//    - y wraps IMG_HEIGHT-1 -> 0.
//  - Config: on in_valid & in_sof, thr_q <= cfg_threshold and mode_q <= cfg_mode.
//    The SOF beat itself already uses the new values. Changes mid-frame are ignored.
//  - Stage 1 (on in_valid):
//    - Window shifts one column; the new column is {linebuf[N-2..0][x], in_pix}.
//    - Line buffers read and then write at address x (read-before-write),
//      forming a chain of N_SIZE-1 rows of IMG_WIDTH x COLORS.
//    - Stage-1 valid = in_valid.
//  - Stage 2 (every cycle), per colour c:
//    - cnt[c] = sum over the NxN window of bit c (CW bits, no overflow).
//    - mode 0: out = (cnt >= thr_q) & centre[c].
//    - mode 1: out = (cnt >= thr_q).
//    - thr_q = 0: every non-border output in mode 1 is 1.
//  - Border:
//    - out_border = (x < 2H) | (y < 2H) of the originating beat.
//    - When set, out_pix is forced to 0. This masks stale line-buffer data and
//      columns wrapped from the previous line.
//  - Latency: fixed 2 cycles. Input beat at cycle t produces out_valid at t+2.
//    Gaps are preserved exactly; there is no backpressure.
//  - Output beat k describes the pixel at (x_k - H, y_k - H). The stream is shifted by
//    (H,H), and the last H rows/cols of the output frame come from the next frame's
//    early beats, which are flagged out_border.
//  - Mid-frame SOF: counters restart immediately. Border masking covers stale buffers.
//  - Reset mid-operation: the beats in flight are dropped (out_valid = 0 the next
//    cycle after rst).
// TESTING (N_SIZE=3, COLORS=2, IMG_WIDTH=8, IMG_HEIGHT=6)
//  1. Hold rst 2 cycles with in_valid=1 -> out_valid=0, out_pix=0 throughout;
//     the first beat after release gives out_valid exactly 2 cycles later.
//  2. All-ones frame, thr=9, mode 0 -> beats with x>=2 & y>=2 give out_pix=2'b11;
//     all other beats give out_border=1, out_pix=0.
//  3. Single pixel 2'b01 at (4,3), thr=2, mode 0 -> all outputs 0;
//     same frame with mode 1, thr=1 -> out_pix[0]=1 on the 9 beats with x in 4..6,
//     y in 3..5.
//  4. Window with exactly 5 ones of colour 1 and the centre set:
//     thr=5 -> out_pix[1]=1; thr=6 -> out_pix[1]=0.
//  5. Frame 2 replayed with random in_valid gaps (0-3 cycles) -> identical output
//     sequence to test 2, each beat at t+2, gaps preserved.
//  6. cfg_threshold changed 9->1 at beat (3,3), then SOF at beat (5,4) ->
//     - thr stays 9 until the SOF beat, then 1;
//     - the SOF beat restarts x=y=0;
//     - outputs stay 0 (border) for the next 2 rows + 2 pixels.

Source files
------------

// File: rtl/stream_denoise.sv
// -----------------------------------------------------------------------------
// stream_denoise
//
// Streaming NxN neighbourhood denoiser for raster-order colour-mask pixels.
// The NxN window is built internally from N_SIZE-1 line buffers. For each
// colour channel the set bits in the window are counted and compared with a
// threshold that is latched once per frame. The output is a denoised mask for
// the window centre, which is (x-H, y-H) relative to the input beat.
// Latency is fixed at 2 cycles, input gaps are preserved, and there is no
// backpressure.
//
// Ports
//   clk            pixel clock
//   rst            synchronous, active-high reset
//   in_valid       input beat strobe (gaps allowed)
//   in_sof         first pixel of frame, qualified by in_valid
//   in_pix         colour mask of the current pixel (COLORS bits)
//   cfg_threshold  neighbourhood threshold, sampled on the SOF beat
//   cfg_mode       0 = clear (centre must be set), 1 = fill; sampled on SOF
//   out_valid      output beat strobe
//   out_sof        in_sof delayed with its beat
//   out_border     window centre lies within H of the top/left image edge
//   out_pix        denoised mask for the window centre (0 when out_border)
// -----------------------------------------------------------------------------
module stream_denoise #(
  parameter int N_SIZE     = 5,
  parameter int COLORS     = 1,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int DEF_THRESH = 13,
  localparam int CW        = $clog2(N_SIZE * N_SIZE + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic [COLORS-1:0] in_pix,
  input  logic [CW-1:0]     cfg_threshold,
  input  logic              cfg_mode,
  output logic              out_valid,
  output logic              out_sof,
  output logic              out_border,
  output logic [COLORS-1:0] out_pix
);

  localparam int H  = N_SIZE / 2;
  localparam int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  // Raster position counters and per-frame configuration.
  logic [XW-1:0] x_q, cur_x, nxt_x;
  logic [YW-1:0] y_q, cur_y, nxt_y;
  logic [CW-1:0] thr_q;
  logic          mode_q;

  // lb[0] holds the previous line, lb[N_SIZE-2] the oldest line.
  logic [COLORS-1:0] lb [N_SIZE-1][IMG_WIDTH];
  // win[row][col]: row N_SIZE-1 is the current line, col N_SIZE-1 the newest pixel.
  logic [COLORS-1:0] win [N_SIZE][N_SIZE];
  logic [COLORS-1:0] new_col [N_SIZE];

  // Stage-1 sideband travelling with the window contents.
  logic          s1_valid, s1_sof, s1_border, s1_mode;
  logic [CW-1:0] s1_thr;

  logic [CW-1:0]     cnt [COLORS];
  logic [COLORS-1:0] res;

  // The SOF beat itself is position (0,0), whatever the counters say.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    cur_x = in_sof ? '0 : x_q;
    cur_y = in_sof ? '0 : y_q;
    nxt_x = cur_x + XW'(1);
    nxt_y = cur_y;
    if (cur_x == XW'(IMG_WIDTH - 1)) begin
      nxt_x = '0;
      nxt_y = (cur_y == YW'(IMG_HEIGHT - 1)) ? '0 : cur_y + YW'(1);
    end
  end

  // New window column: the oldest line on top, the incoming pixel at the bottom.
  always_comb begin
    new_col[N_SIZE-1] = in_pix;
    for (int r = 0; r < N_SIZE - 1; r++) begin
      new_col[r] = lb[N_SIZE-2-r][cur_x];
    end
  end

  // NOTE: line buffers and the window are deliberately left without reset.
  // Clearing a memory costs a write port per cycle, and the border flag already
  // masks every output that could see stale contents.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      for (int r = 0; r < N_SIZE; r++) begin
        for (int c = 0; c < N_SIZE - 1; c++) begin
          win[r][c] <= win[r][c+1];
        end
        win[r][N_SIZE-1] <= new_col[r];
      end
      // The reads above see the old contents because writes are non-blocking,
      // which gives the read-before-write shift along the line chain.
      lb[0][cur_x] <= in_pix;
      for (int i = 1; i < N_SIZE - 1; i++) begin
        lb[i][cur_x] <= lb[i-1][cur_x];
      end
    end
  end

  // Per-colour population count and threshold decision.
  always_comb begin
    res = '0;
    for (int k = 0; k < COLORS; k++) begin
      cnt[k] = '0;
      for (int r = 0; r < N_SIZE; r++) begin
        for (int c = 0; c < N_SIZE; c++) begin
          cnt[k] = cnt[k] + CW'(win[r][c][k]);
        end
      end
      res[k] = (cnt[k] >= s1_thr) && (s1_mode || win[H][H][k]);
    end
  end

  // NOTE: all sequential state uses non-blocking assignment so that every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q        <= '0;
      y_q        <= '0;
      thr_q      <= CW'(DEF_THRESH);
      mode_q     <= 1'b0;
      s1_valid   <= 1'b0;
      s1_sof     <= 1'b0;
      s1_border  <= 1'b0;
      s1_mode    <= 1'b0;
      s1_thr     <= '0;
      out_valid  <= 1'b0;
      out_sof    <= 1'b0;
      out_border <= 1'b0;
      out_pix    <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        x_q       <= nxt_x;
        y_q       <= nxt_y;
        s1_sof    <= in_sof;
        s1_border <= (cur_x < XW'(2 * H)) || (cur_y < YW'(2 * H));
        // The SOF beat already uses the new configuration, so it is bypassed
        // into stage 1 on the same edge that latches it.
        s1_thr    <= in_sof ? cfg_threshold : thr_q;
        s1_mode   <= in_sof ? cfg_mode : mode_q;
        if (in_sof) begin
          thr_q  <= cfg_threshold;
          mode_q <= cfg_mode;
        end
      end
      out_valid  <= s1_valid;
      out_sof    <= s1_valid && s1_sof;
      out_border <= s1_valid && s1_border;
      out_pix    <= (s1_valid && !s1_border) ? res : '0;
    end
  end

endmodule

// File: tb/tb_stream_denoise.sv
// -----------------------------------------------------------------------------
// tb_stream_denoise
//
// Directed bench for stream_denoise with N_SIZE=3, COLORS=2, 8x6 frames.
// Every driven beat pushes its expected output (cycle stamp, sof, border, mask)
// into a scoreboard. The mask is computed directly from a bench-side image of
// the frame. A negedge monitor pops and compares each output beat.
// -----------------------------------------------------------------------------
module tb_stream_denoise;

  localparam int N  = 3;
  localparam int C  = 2;
  localparam int W  = 8;
  localparam int HT = 6;
  localparam int CW = $clog2(N * N + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b1;
  logic          in_sof = 1'b0;
  logic [C-1:0]  in_pix = 2'b11;
  logic [CW-1:0] cfg_threshold = CW'(9);
  logic          cfg_mode = 1'b0;
  logic          out_valid, out_sof, out_border;
  logic [C-1:0]  out_pix;

  stream_denoise #(
    .N_SIZE(N), .COLORS(C), .IMG_WIDTH(W), .IMG_HEIGHT(HT), .DEF_THRESH(13)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_pix(in_pix),
    .cfg_threshold(cfg_threshold), .cfg_mode(cfg_mode),
    .out_valid(out_valid), .out_sof(out_sof), .out_border(out_border), .out_pix(out_pix)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         stamp;
    logic [3:0] res;   // {sof, border, pix[1:0]}
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Bench-side image and raster position of the next beat.
  logic [C-1:0]  img [HT][W];
  int            bx = 0;
  int            by = 0;
  logic [CW-1:0] m_thr = '0;
  logic          m_mode = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one beat after 'gap' idle cycles and push its expected output.
  task automatic send(input logic [C-1:0] pix, input logic sof, input int gap);
    exp_t       e;
    int         cnt;
    logic [C-1:0] p;
    repeat (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_sof   = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_sof   = sof;
    in_pix   = pix;
    if (sof) begin
      bx     = 0;
      by     = 0;
      m_thr  = cfg_threshold;
      m_mode = cfg_mode;
    end
    img[by][bx] = pix;
    p = '0;
    if (bx >= 2 && by >= 2) begin
      for (int k = 0; k < C; k++) begin
        cnt = 0;
        for (int r = 0; r < 3; r++)
          for (int q = 0; q < 3; q++)
            cnt += int'(img[by-r][bx-q][k]);
        p[k] = (cnt >= int'(m_thr)) && (m_mode || img[by-1][bx-1][k]);
      end
    end
    e.stamp = cyc + 2;
    e.res   = {sof, (bx < 2 || by < 2), p};
    sb.push_back(e);
    bx++;
    if (bx == W) begin
      bx = 0;
      by = (by == HT - 1) ? 0 : by + 1;
    end
  endtask

  function automatic logic [C-1:0] pat(input int kind, input int x, input int y);
    case (kind)
      0:       return 2'b11;
      1:       return (x == 4 && y == 3) ? 2'b01 : 2'b00;
      2:       return ((x == 3 && y == 2) || (x == 5 && y == 2) || (x == 4 && y == 3) ||
                       (x == 3 && y == 4) || (x == 5 && y == 4)) ? 2'b10 : 2'b00;
      default: return C'($urandom_range(0, 3));
    endcase
  endfunction

  task automatic frame(input int kind, input bit gaps);
    for (int i = 0; i < W * HT; i++) begin
      send(pat(kind, i % W, i / W), i == 0, gaps ? int'($urandom_range(0, 3)) : 0);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_sof   = 1'b0;
    end
  endtask

  // Output monitor: every output beat must match the oldest expected entry,
  // including the exact cycle it was due.
  always @(negedge clk) begin
    if (!rst && out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_beat", 32'(sb.size()), 32'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("latency", 32'(cyc), 32'(e.stamp));
        check("beat", {28'd0, out_sof, out_border, out_pix}, {28'd0, e.res});
      end
    end
  end

  initial begin
    // Reset held two cycles with in_valid high: outputs stay cleared.
    repeat (2) begin
      @(negedge clk);
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_pix", {30'd0, out_pix}, 32'd0);
    end
    rst      = 1'b0;
    in_valid = 1'b0;

    // All-ones frame, thr=9, clear mode.
    cfg_threshold = CW'(9); cfg_mode = 1'b0;
    frame(0, 1'b0);

    // Single pixel: suppressed in clear mode thr=2, spread in fill mode thr=1.
    cfg_threshold = CW'(2);
    frame(1, 1'b0);
    cfg_threshold = CW'(1); cfg_mode = 1'b1;
    frame(1, 1'b0);

    // Exactly five colour-1 ones around (4,3): thr=5 passes, thr=6 does not.
    cfg_threshold = CW'(5); cfg_mode = 1'b0;
    frame(2, 1'b0);
    cfg_threshold = CW'(6);
    frame(2, 1'b0);

    // All-ones frame again with random input gaps.
    cfg_threshold = CW'(9);
    frame(0, 1'b1);

    // Threshold changed mid-frame at (3,3) is ignored; SOF at (5,4) restarts.
    cfg_threshold = CW'(9); cfg_mode = 1'b0;
    for (int i = 0; i < 4 * W + 5; i++) begin
      if (i == 3 * W + 3) cfg_threshold = CW'(1);
      send(pat(3, 0, 0), i == 0, 0);
    end
    frame(3, 1'b0);

    idle(6);
    check("drain", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
